// File: rtl/csr_row_streamer.sv
// Streams a 4x4 CSR weight matrix row by row to the sparse MVM engine,
// dropping entries whose column has no spike and closing each row with an EOR beat.
module csr_row_streamer #(
  parameter int MAX_NNZ = 16,
  parameter int VAL_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [3:0]       wr_addr,
  input  logic [VAL_W+1:0] wr_data,
  input  logic             start,
  input  logic [3:0]       spike_train,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       out_row,
  output logic [1:0]       out_col,
  output logic [VAL_W-1:0] out_value,
  output logic             out_eor,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int ADDR_W = $clog2(MAX_NNZ);
  localparam int PTR_W  = $clog2(MAX_NNZ + 1);

  typedef enum logic [1:0] {IDLE, CHECK, STREAM, DONE} state_t;

  state_t             state, state_next;
  logic [VAL_W+1:0]   ent [MAX_NNZ];
  logic [PTR_W-1:0]   rp  [5];
  logic [3:0]         spk;
  logic [1:0]         row;
  logic [PTR_W-1:0]   ptr;

  logic [PTR_W-1:0]   row_end;
  logic [VAL_W+1:0]   cur_ent;
  logic               have_ent;
  logic               hit;
  logic               table_ok;

  assign row_end  = rp[3'({1'b0, row}) + 3'd1];
  assign cur_ent  = ent[ptr[ADDR_W-1:0]];
  assign have_ent = (ptr < row_end);
  assign hit      = spk[cur_ent[VAL_W+1:VAL_W]];
  assign table_ok = (rp[0] == '0) && (rp[1] >= rp[0]) && (rp[2] >= rp[1]) &&
                    (rp[3] >= rp[2]) && (rp[4] >= rp[3]) &&
                    (rp[4] <= PTR_W'(MAX_NNZ));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Matrix store only accepts writes while idle so a running stream sees a frozen table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NNZ; i++) ent[i] <= '0;
      for (int i = 0; i < 5; i++) rp[i] <= '0;
    end else if (wr_en && state == IDLE) begin
      if (!wr_sel) begin
        ent[wr_addr[ADDR_W-1:0]] <= wr_data;
      end else if (wr_addr <= 4'd4) begin
        rp[wr_addr[2:0]] <= wr_data[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      spk   <= '0;
      row   <= '0;
      ptr   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          spk <= spike_train;
          row <= '0;
          ptr <= rp[0];
          err <= 1'b0;
        end
        CHECK: if (!table_ok) err <= 1'b1;
        STREAM: begin
          if (have_ent) begin
            // A skipped entry advances without a handshake.
            if (!hit || out_ready) ptr <= ptr + 1'b1;
          end else if (out_ready && row != 2'd3) begin
            row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_row    = '0;
    out_col    = '0;
    out_value  = '0;
    out_eor    = 1'b0;
    case (state)
      IDLE:  if (start) state_next = CHECK;
      CHECK: state_next = table_ok ? STREAM : DONE;
      STREAM: begin
        if (have_ent) begin
          if (hit) begin
            out_valid = 1'b1;
            out_row   = row;
            out_col   = cur_ent[VAL_W+1:VAL_W];
            out_value = cur_ent[VAL_W-1:0];
          end
        end else begin
          out_valid = 1'b1;
          out_row   = row;
          out_eor   = 1'b1;
          if (out_ready && row == 2'd3) state_next = DONE;
        end
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_row_streamer.sv
// Directed bench for csr_row_streamer: beat order, spike gating, backpressure,
// malformed tables, busy rules and mid-stream reset.
module tb_csr_row_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_sel, start, out_ready;
  logic [3:0] wr_addr, spike_train;
  logic [9:0] wr_data;
  logic       out_valid, out_eor, busy, done, err;
  logic [1:0] out_row, out_col;
  logic [7:0] out_value;

  int checks = 0;
  int failures = 0;
  logic [13:0] seq [8];

  csr_row_streamer #(.MAX_NNZ(16), .VAL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .spike_train(spike_train), .out_ready(out_ready),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_value(out_value),
    .out_eor(out_eor), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ent_beat(int r, int c, int v);
    return {1'b1, 2'(r), 2'(c), 8'(v), 1'b0};
  endfunction

  function automatic logic [13:0] eor_beat(int r);
    return {1'b1, 2'(r), 2'd0, 8'd0, 1'b1};
  endfunction

  function automatic logic [13:0] obs_beat();
    return {out_valid, out_row, out_col, out_value, out_eor};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [9:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_rp(input int a, input int b, input int c, input int d, input int e);
    wr(1'b1, 0, 10'(a)); wr(1'b1, 1, 10'(b)); wr(1'b1, 2, 10'(c));
    wr(1'b1, 3, 10'(d)); wr(1'b1, 4, 10'(e));
  endtask

  // Leaves the bench in cycle T+1, with T the edge that sampled start.
  task automatic start_stream(input logic [3:0] spk);
    spike_train = spk; start = 1'b1;
    tick();
    start = 1'b0; spike_train = 4'b0000;
  endtask

  task automatic check_seq(input string tag, input int first, input int n);
    for (int i = first; i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), 32'(obs_beat()), 32'(seq[i]));
      tick();
    end
    chk({tag, "_done"}, 32'({done, busy}), 32'b11);
    tick();
    chk({tag, "_idle"}, 32'({done, busy}), 32'b00);
  endtask

  initial begin
    logic [3:0] pat;
    int idx;
    int k;

    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; spike_train = '0; out_ready = 1'b1;
    tick();
    chk("reset_outputs", 32'({obs_beat(), busy, done, err}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Diagonal matrix, all columns spiking
    load_rp(0, 1, 2, 3, 4);
    for (int i = 0; i < 4; i++) wr(1'b0, i, {2'(i), 8'(10 + i)});
    seq[0] = ent_beat(0, 0, 10); seq[1] = eor_beat(0);
    seq[2] = ent_beat(1, 1, 11); seq[3] = eor_beat(1);
    seq[4] = ent_beat(2, 2, 12); seq[5] = eor_beat(2);
    seq[6] = ent_beat(3, 3, 13); seq[7] = eor_beat(3);
    start_stream(4'b1111);
    chk("diag_check_cycle", 32'({busy, out_valid}), 32'b10);
    tick();
    check_seq("diag", 0, 8);

    // Columns 1 and 3 silent: their entries become idle cycles
    seq[2] = 14'd0; seq[6] = 14'd0;
    start_stream(4'b0101);
    tick();
    check_seq("gate", 0, 8);

    // Empty rows around one dense row, with backpressure
    load_rp(0, 0, 3, 3, 3);
    wr(1'b0, 0, {2'd1, 8'd5}); wr(1'b0, 1, {2'd2, 8'd6}); wr(1'b0, 2, {2'd3, 8'd7});
    seq[0] = eor_beat(0);
    seq[1] = ent_beat(1, 1, 5); seq[2] = ent_beat(1, 2, 6); seq[3] = ent_beat(1, 3, 7);
    seq[4] = eor_beat(1); seq[5] = eor_beat(2); seq[6] = eor_beat(3);
    start_stream(4'b1111);
    tick();
    pat = 4'b1001;
    idx = 0;
    k = 0;
    while (idx < 7 && k < 40) begin
      out_ready = pat[k % 4];
      chk($sformatf("bp_cycle%0d", k), 32'(obs_beat()), 32'(seq[idx]));
      if (out_ready) idx++;
      tick();
      k++;
    end
    out_ready = 1'b1;
    chk("bp_all_beats", 32'(idx), 32'd7);
    chk("bp_done", 32'(done), 32'd1);
    tick();

    // Malformed row pointers: error path, no beats
    load_rp(0, 3, 2, 4, 4);
    start_stream(4'b1111);
    chk("bad_t1", 32'({out_valid, done, err}), 32'b000);
    tick();
    chk("bad_t2", 32'({out_valid, done, err}), 32'b011);
    tick();
    chk("bad_sticky", 32'({busy, done, err}), 32'b001);
    tick();
    chk("bad_sticky_later", 32'(err), 32'd1);

    // Valid table again: err clears on the accepted start
    load_rp(0, 1, 2, 3, 4);
    seq[0] = ent_beat(0, 1, 5); seq[1] = eor_beat(0);
    seq[2] = ent_beat(1, 2, 6); seq[3] = eor_beat(1);
    seq[4] = ent_beat(2, 3, 7); seq[5] = eor_beat(2);
    seq[6] = ent_beat(3, 3, 13); seq[7] = eor_beat(3);
    start_stream(4'b1111);
    chk("recover_err_clear", 32'(err), 32'd0);
    tick();
    check_seq("recover", 0, 8);

    // Start and entry writes during streaming are ignored
    for (int i = 0; i < 3; i++) wr(1'b0, i, {2'(i), 8'(10 + i)});
    seq[0] = ent_beat(0, 0, 10); seq[2] = ent_beat(1, 1, 11); seq[4] = ent_beat(2, 2, 12);
    start_stream(4'b1111);
    tick();
    start = 1'b1; spike_train = 4'b0001;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd3; wr_data = {2'd0, 8'd99};
    chk("busy_beat0", 32'(obs_beat()), 32'(seq[0]));
    tick();
    start = 1'b0; spike_train = 4'b0000; wr_en = 1'b0;
    check_seq("busy", 1, 8);

    // Reset in the middle of row 1
    start_stream(4'b1111);
    tick(); tick(); tick();
    chk("rst_pre_beat", 32'(obs_beat()), 32'(ent_beat(1, 1, 11)));
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({obs_beat(), busy, done, err}), 32'd0);
    @(posedge clk); #1;
    chk("rst_held_no_done", 32'({done, busy}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_after_no_done", 32'({done, busy, out_valid}), 32'd0);

    // Cleared storage yields only EOR beats
    for (int i = 0; i < 4; i++) seq[i] = eor_beat(i);
    start_stream(4'b1111);
    tick();
    check_seq("cleared", 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
